// File: rtl/aemb2_wb_arb.sv
// aemb2_wb_arb: round-robin arbiter letting the AEMB2 instruction (iwb) and
// data (dwb) Wishbone ports share one memory slave port (mwb).
// One transfer is outstanding at a time. A watchdog completes transfers
// whose slave never acknowledges, and raises a sticky timeout flag.
module aemb2_wb_arb #(
  parameter int AW  = 18,
  parameter int TMO = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  // instruction master
  input  logic [AW-1:2] iwb_adr_i,
  input  logic          iwb_stb_i,
  input  logic [3:0]    iwb_sel_i,
  input  logic          iwb_tag_i,
  output logic          iwb_ack_o,
  output logic [31:0]   iwb_dat_o,
  // data master
  input  logic [AW-1:2] dwb_adr_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic          dwb_tag_i,
  input  logic [31:0]   dwb_dat_i,
  output logic          dwb_ack_o,
  output logic [31:0]   dwb_dat_o,
  // shared slave
  output logic [AW-1:2] mwb_adr_o,
  output logic          mwb_stb_o,
  output logic          mwb_cyc_o,
  output logic          mwb_wre_o,
  output logic [3:0]    mwb_sel_o,
  output logic          mwb_tag_o,
  output logic [31:0]   mwb_dat_o,
  input  logic          mwb_ack_i,
  input  logic [31:0]   mwb_dat_i,
  // status
  output logic [1:0]    arb_gnt_o,
  output logic          arb_tmo_o
);

  // State encoding doubles as the arb_gnt_o pattern.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  // Counter value at which an unacknowledged transfer is forced to finish.
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t        r_state;
  logic [15:0]   r_tmoCnt;
  logic          r_lastD;
  logic          r_tmo;
  logic [1:0]    r_gnt;
  logic [AW-1:2] r_adr;
  logic          r_stb;
  logic          r_wre;
  logic [3:0]    r_sel;
  logic          r_tag;
  logic [31:0]   r_dat;

  logic w_pickD;
  logic w_pickI;
  logic w_tmoHit;
  logic w_done;
  logic w_inI;
  logic w_inD;

  // On a tie, the master that was not served last wins; dwb wins otherwise
  // only when it is the sole requester.
  assign w_pickD = dwb_stb_i && (!iwb_stb_i || !r_lastD);
  assign w_pickI = iwb_stb_i && !w_pickD;

  assign w_inI = (r_state == GNT_I);
  assign w_inD = (r_state == GNT_D);

  // The watchdog fires only when the slave stays silent in the last allowed
  // cycle; a real ack in that cycle takes precedence.
  assign w_tmoHit = (w_inI || w_inD) && !mwb_ack_i && (r_tmoCnt == TMO_LAST);
  assign w_done   = (w_inI || w_inD) && (mwb_ack_i || w_tmoHit);

  // Ack and read data reach only the granted master; a forced completion
  // returns zero data instead of whatever the slave bus carries.
  assign iwb_ack_o = w_inI && (mwb_ack_i || w_tmoHit);
  assign dwb_ack_o = w_inD && (mwb_ack_i || w_tmoHit);
  assign iwb_dat_o = (w_inI && !w_tmoHit) ? mwb_dat_i : 32'h0;
  assign dwb_dat_o = (w_inD && !w_tmoHit) ? mwb_dat_i : 32'h0;

  assign mwb_adr_o = r_adr;
  assign mwb_stb_o = r_stb;
  assign mwb_cyc_o = r_stb;
  assign mwb_wre_o = r_wre;
  assign mwb_sel_o = r_sel;
  assign mwb_tag_o = r_tag;
  assign mwb_dat_o = r_dat;
  assign arb_gnt_o = r_gnt;
  assign arb_tmo_o = r_tmo;

  // Arbitration FSM: latches the winner's request in IDLE, then holds it
  // until the slave acks or the watchdog expires.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state  <= IDLE;
      r_tmoCnt <= 16'h0;
      r_lastD  <= 1'b0;
      r_tmo    <= 1'b0;
      r_gnt    <= 2'b00;
      r_adr    <= '0;
      r_stb    <= 1'b0;
      r_wre    <= 1'b0;
      r_sel    <= 4'h0;
      r_tag    <= 1'b0;
      r_dat    <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickD) begin
            r_state  <= GNT_D;
            r_gnt    <= 2'b10;
            r_tmoCnt <= 16'h0;
            r_stb    <= 1'b1;
            r_adr    <= dwb_adr_i;
            r_wre    <= dwb_wre_i;
            r_sel    <= dwb_sel_i;
            r_tag    <= dwb_tag_i;
            r_dat    <= dwb_dat_i;
          end else if (w_pickI) begin
            r_state  <= GNT_I;
            r_gnt    <= 2'b01;
            r_tmoCnt <= 16'h0;
            r_stb    <= 1'b1;
            r_adr    <= iwb_adr_i;
            r_wre    <= 1'b0;
            r_sel    <= iwb_sel_i;
            r_tag    <= iwb_tag_i;
            r_dat    <= 32'h0;
          end
        end
        GNT_I, GNT_D: begin
          if (w_done) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_stb   <= 1'b0;
            r_wre   <= 1'b0;
            r_lastD <= w_inD;
            if (w_tmoHit) begin
              r_tmo <= 1'b1;
            end
          end else begin
            r_tmoCnt <= r_tmoCnt + 16'h1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_stb   <= 1'b0;
          r_wre   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb2_wb_arb.sv
// tb_aemb2_wb_arb: scoreboard bench for the two-master Wishbone arbiter.
// Master and slave behaviour are modelled by free-running processes; each
// request pushes the grant it should produce, and a monitor pops and
// compares whenever the arbiter starts a slave cycle or acks a master.
module tb_aemb2_wb_arb;

  localparam int AW  = 18;
  localparam int TMO = 8;

  typedef struct {
    logic [15:0] adr;
    logic [3:0]  sel;
    logic        tag;
    logic        wre;
    logic [31:0] dat;
  } req_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] adr;
    logic        wre;
    logic [3:0]  sel;
    logic        tag;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  logic          sys_clk_i;
  logic          sys_rst_i;
  logic [AW-1:2] iwb_adr_i;
  logic          iwb_stb_i;
  logic [3:0]    iwb_sel_i;
  logic          iwb_tag_i;
  logic          iwb_ack_o;
  logic [31:0]   iwb_dat_o;
  logic [AW-1:2] dwb_adr_i;
  logic          dwb_stb_i;
  logic          dwb_wre_i;
  logic [3:0]    dwb_sel_i;
  logic          dwb_tag_i;
  logic [31:0]   dwb_dat_i;
  logic          dwb_ack_o;
  logic [31:0]   dwb_dat_o;
  logic [AW-1:2] mwb_adr_o;
  logic          mwb_stb_o;
  logic          mwb_cyc_o;
  logic          mwb_wre_o;
  logic [3:0]    mwb_sel_o;
  logic          mwb_tag_o;
  logic [31:0]   mwb_dat_o;
  logic          mwb_ack_i;
  logic [31:0]   mwb_dat_i;
  logic [1:0]    arb_gnt_o;
  logic          arb_tmo_o;

  int testsRun  = 0;
  int failCount = 0;

  req_t iReq[$];
  req_t dReq[$];
  exp_t expQ[$];
  req_t iCur;
  req_t dCur;
  bit   iBusy    = 0;
  bit   dBusy    = 0;
  bit   iAckSeen = 0;
  bit   dAckSeen = 0;

  exp_t cur;
  bit   curValid = 0;
  bit   prevStb  = 0;
  int   grantCyc = 0;
  int   ackCnt   = 0;

  int          slaveLat   = 0;
  int          sCnt       = 0;
  logic [31:0] slaveRdata = 32'h0;

  aemb2_wb_arb #(.AW(AW), .TMO(TMO)) dut (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .iwb_adr_i(iwb_adr_i),
    .iwb_stb_i(iwb_stb_i),
    .iwb_sel_i(iwb_sel_i),
    .iwb_tag_i(iwb_tag_i),
    .iwb_ack_o(iwb_ack_o),
    .iwb_dat_o(iwb_dat_o),
    .dwb_adr_i(dwb_adr_i),
    .dwb_stb_i(dwb_stb_i),
    .dwb_wre_i(dwb_wre_i),
    .dwb_sel_i(dwb_sel_i),
    .dwb_tag_i(dwb_tag_i),
    .dwb_dat_i(dwb_dat_i),
    .dwb_ack_o(dwb_ack_o),
    .dwb_dat_o(dwb_dat_o),
    .mwb_adr_o(mwb_adr_o),
    .mwb_stb_o(mwb_stb_o),
    .mwb_cyc_o(mwb_cyc_o),
    .mwb_wre_o(mwb_wre_o),
    .mwb_sel_o(mwb_sel_o),
    .mwb_tag_o(mwb_tag_o),
    .mwb_dat_o(mwb_dat_o),
    .mwb_ack_i(mwb_ack_i),
    .mwb_dat_i(mwb_dat_i),
    .arb_gnt_o(arb_gnt_o),
    .arb_tmo_o(arb_tmo_o)
  );

  // Free-running system clock
  initial begin
    sys_clk_i = 1'b0;
    forever #5 sys_clk_i = ~sys_clk_i;
  end

  // Single comparison point: counts every check, reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Queue one master request and the grant it should produce
  task automatic applyStimulus(input bit isD, input logic [15:0] adr, input logic [3:0] sel,
                               input logic tag, input logic wre, input logic [31:0] dat,
                               input logic [31:0] rdata, input int cycles);
    req_t r;
    exp_t e;
    r.adr = adr; r.sel = sel; r.tag = tag; r.wre = wre; r.dat = dat;
    e.gnt    = isD ? 2'b10 : 2'b01;
    e.adr    = adr;
    e.sel    = sel;
    e.tag    = tag;
    e.wre    = isD ? wre : 1'b0;
    e.dat    = isD ? dat : 32'h0;
    e.rdata  = rdata;
    e.cycles = cycles;
    if (isD) dReq.push_back(r);
    else     iReq.push_back(r);
    expQ.push_back(e);
  endtask

  // Wait until every queued request has been granted and completed
  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while ((expQ.size() != 0 || curValid || iBusy || dBusy) && n < maxCyc) begin
      @(negedge sys_clk_i);
      n++;
    end
    checkOutput("drainInTime", 32'(n < maxCyc), 32'd1);
  endtask

  // Instruction master: holds stb until ack, scrambles its other inputs while granted
  always begin
    @(posedge sys_clk_i);
    #1;
    if (sys_rst_i) begin
      iwb_stb_i = 1'b0;
      iBusy     = 0;
    end else begin
      if (iBusy && iAckSeen) begin
        iBusy     = 0;
        iwb_stb_i = 1'b0;
      end
      iAckSeen = 0;
      if (iBusy && arb_gnt_o == 2'b01) begin
        iwb_adr_i = ~iwb_adr_i;
        iwb_sel_i = ~iwb_sel_i;
        iwb_tag_i = ~iwb_tag_i;
      end
      if (!iBusy && iReq.size() != 0) begin
        iCur      = iReq.pop_front();
        iwb_adr_i = iCur.adr;
        iwb_sel_i = iCur.sel;
        iwb_tag_i = iCur.tag;
        iwb_stb_i = 1'b1;
        iBusy     = 1;
      end
    end
  end

  // Data master: same protocol as the instruction master, plus write data
  always begin
    @(posedge sys_clk_i);
    #1;
    if (sys_rst_i) begin
      dwb_stb_i = 1'b0;
      dBusy     = 0;
    end else begin
      if (dBusy && dAckSeen) begin
        dBusy     = 0;
        dwb_stb_i = 1'b0;
      end
      dAckSeen = 0;
      if (dBusy && arb_gnt_o == 2'b10) begin
        dwb_adr_i = ~dwb_adr_i;
        dwb_sel_i = ~dwb_sel_i;
        dwb_tag_i = ~dwb_tag_i;
        dwb_wre_i = ~dwb_wre_i;
        dwb_dat_i = ~dwb_dat_i;
      end
      if (!dBusy && dReq.size() != 0) begin
        dCur      = dReq.pop_front();
        dwb_adr_i = dCur.adr;
        dwb_sel_i = dCur.sel;
        dwb_tag_i = dCur.tag;
        dwb_wre_i = dCur.wre;
        dwb_dat_i = dCur.dat;
        dwb_stb_i = 1'b1;
        dBusy     = 1;
      end
    end
  end

  // Slave: acks in the slaveLat-th cycle of stb; slaveLat of 0 means never ack
  always begin
    @(posedge sys_clk_i);
    #1;
    if (sys_rst_i) begin
      mwb_ack_i = 1'b0;
      mwb_dat_i = 32'h0;
      sCnt      = 0;
    end else if (slaveLat != 0) begin
      if (mwb_ack_i) begin
        mwb_ack_i = 1'b0;
        mwb_dat_i = 32'h0;
        sCnt      = 0;
      end else if (mwb_stb_o) begin
        sCnt++;
        if (sCnt == slaveLat) begin
          mwb_ack_i = 1'b1;
          mwb_dat_i = slaveRdata;
        end
      end else begin
        sCnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new slave cycle and checks each master ack
  always @(negedge sys_clk_i) begin
    if (sys_rst_i) begin
      prevStb  = 0;
      curValid = 0;
      iAckSeen = 0;
      dAckSeen = 0;
    end else begin
      if (mwb_stb_o && !prevStb) begin
        checkOutput("grantExpected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          cur      = expQ.pop_front();
          curValid = 1;
          grantCyc = 1;
          ackCnt   = 0;
          checkOutput("gnt", 32'(arb_gnt_o), 32'(cur.gnt));
          checkOutput("adr", 32'(mwb_adr_o), 32'(cur.adr));
          checkOutput("wre", 32'(mwb_wre_o), 32'(cur.wre));
          checkOutput("sel", 32'(mwb_sel_o), 32'(cur.sel));
          checkOutput("tag", 32'(mwb_tag_o), 32'(cur.tag));
          checkOutput("wdat", mwb_dat_o, cur.dat);
          checkOutput("cyc", 32'(mwb_cyc_o), 32'd1);
        end
      end else if (mwb_stb_o) begin
        grantCyc++;
      end
      if (!mwb_stb_o && prevStb && curValid) begin
        checkOutput("ackCount", 32'(ackCnt), 32'd1);
        curValid = 0;
      end
      if (iwb_ack_o || dwb_ack_o) begin
        checkOutput("ackInGrant", 32'(curValid && arb_gnt_o != 2'b00), 32'd1);
        if (curValid) begin
          ackCnt++;
          checkOutput("ackWho", 32'({dwb_ack_o, iwb_ack_o}), 32'(cur.gnt));
          checkOutput("ackDat", (cur.gnt == 2'b01) ? iwb_dat_o : dwb_dat_o, cur.rdata);
          checkOutput("otherDat", (cur.gnt == 2'b01) ? dwb_dat_o : iwb_dat_o, 32'h0);
          checkOutput("ackCycle", 32'(grantCyc), 32'(cur.cycles));
          checkOutput("holdAdr", 32'(mwb_adr_o), 32'(cur.adr));
          checkOutput("holdSel", 32'(mwb_sel_o), 32'(cur.sel));
          checkOutput("holdTag", 32'(mwb_tag_o), 32'(cur.tag));
          checkOutput("holdDat", mwb_dat_o, cur.dat);
        end
        if (iwb_ack_o) iAckSeen = 1;
        if (dwb_ack_o) dAckSeen = 1;
      end
      prevStb = mwb_stb_o;
    end
  end

  // Test sequence
  initial begin
    int n;
    sys_rst_i = 1'b1;
    iwb_adr_i = '0; iwb_stb_i = 1'b0; iwb_sel_i = 4'h0; iwb_tag_i = 1'b0;
    dwb_adr_i = '0; dwb_stb_i = 1'b0; dwb_wre_i = 1'b0; dwb_sel_i = 4'h0;
    dwb_tag_i = 1'b0; dwb_dat_i = 32'h0;
    mwb_ack_i = 1'b0; mwb_dat_i = 32'h0;

    // Power-on reset state
    repeat (2) @(negedge sys_clk_i);
    checkOutput("rstStb", 32'(mwb_stb_o), 32'd0);
    checkOutput("rstCyc", 32'(mwb_cyc_o), 32'd0);
    checkOutput("rstGnt", 32'(arb_gnt_o), 32'd0);
    checkOutput("rstTmo", 32'(arb_tmo_o), 32'd0);
    checkOutput("rstAcks", 32'({iwb_ack_o, dwb_ack_o}), 32'd0);
    checkOutput("rstWdat", mwb_dat_o, 32'h0);
    sys_rst_i = 1'b0;

    // Single instruction read, slave acks in the 3rd cycle
    slaveLat   = 3;
    slaveRdata = 32'hB800_0000;
    applyStimulus(1'b0, 16'h0040, 4'hF, 1'b1, 1'b0, 32'h0, 32'hB800_0000, 3);
    waitIdle(50);

    // Byte-lane passthrough on data writes
    slaveRdata = 32'h0000_0000;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] selTab [6];
      selTab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};
      applyStimulus(1'b1, 16'h0200 + 16'(k), selTab[k], 1'(k), 1'b1,
                    32'hA5A5_0000 + 32'(k), 32'h0, 3);
    end
    waitIdle(100);

    // Slave acks in the very last watchdog cycle: normal completion
    slaveLat   = TMO;
    slaveRdata = 32'hCAFE_0001;
    applyStimulus(1'b1, 16'h0300, 4'hF, 1'b0, 1'b0, 32'h0, 32'hCAFE_0001, TMO);
    waitIdle(50);
    checkOutput("tmoNotSetByLastAck", 32'(arb_tmo_o), 32'd0);

    // Slave never acks: watchdog completes with zero data
    slaveLat  = 0;
    mwb_dat_i = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 16'h0310, 4'hF, 1'b1, 1'b0, 32'h0, 32'h0, TMO);
    n = 0;
    while (!dwb_ack_o && n < 30) begin
      @(negedge sys_clk_i);
      n++;
    end
    checkOutput("tmoAckSeen", 32'(dwb_ack_o), 32'd1);
    @(negedge sys_clk_i);
    checkOutput("tmoStbDropped", 32'(mwb_stb_o), 32'd0);
    checkOutput("tmoFlagSet", 32'(arb_tmo_o), 32'd1);
    @(posedge sys_clk_i);
    #2;
    mwb_ack_i = 1'b1;
    mwb_dat_i = 32'hDEAD_BEEF;
    @(negedge sys_clk_i);
    checkOutput("lateAckIgnored", 32'({iwb_ack_o, dwb_ack_o}), 32'd0);
    checkOutput("lateDatIgnored", dwb_dat_o, 32'h0);
    @(posedge sys_clk_i);
    #2;
    mwb_ack_i = 1'b0;
    mwb_dat_i = 32'h0;
    waitIdle(20);
    repeat (3) @(negedge sys_clk_i);
    checkOutput("tmoSticky", 32'(arb_tmo_o), 32'd1);

    // Reset asserted between edges while dwb holds the bus
    applyStimulus(1'b1, 16'h0055, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, TMO);
    n = 0;
    while (arb_gnt_o != 2'b10 && n < 20) begin
      @(negedge sys_clk_i);
      n++;
    end
    checkOutput("midGrantReached", 32'(arb_gnt_o), 32'd2);
    @(negedge sys_clk_i);
    #2;
    sys_rst_i = 1'b1;
    #1;
    checkOutput("asyncRstStb", 32'(mwb_stb_o), 32'd0);
    checkOutput("asyncRstGnt", 32'(arb_gnt_o), 32'd0);
    checkOutput("asyncRstAcks", 32'({iwb_ack_o, dwb_ack_o}), 32'd0);
    checkOutput("asyncRstTmo", 32'(arb_tmo_o), 32'd0);
    iReq.delete();
    dReq.delete();
    expQ.delete();
    repeat (2) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;

    // Simultaneous requests right after reset: dwb wins the tie
    slaveLat   = 2;
    slaveRdata = 32'h0BAD_F00D;
    applyStimulus(1'b1, 16'h0100, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 32'h0BAD_F00D, 2);
    applyStimulus(1'b0, 16'h0004, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0BAD_F00D, 2);
    waitIdle(50);

    // Continuous requests from both masters alternate D,I,D,I,D,I
    slaveRdata = 32'h0000_1234;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h0400 + 16'(k), 4'hF, 1'b0, 1'b1, 32'h5000_0000 + 32'(k), 32'h0000_1234, 2);
      applyStimulus(1'b0, 16'h0800 + 16'(k), 4'hF, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 2);
    end
    waitIdle(100);
    checkOutput("finalTmoClear", 32'(arb_tmo_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not complete, got running expected done");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/aemb2_wb_arb.md
Name: aemb2_wb_arb

Overview:
Two-master to one-slave Wishbone arbiter. It lets the AEMB2 core's instruction port (iwb) and data port (dwb) share a single unified memory slave port (mwb). It sits between the core and the unified RAM/ROM model or on-chip block RAM. It provides round-robin fairness, one outstanding transfer at a time, and a bus-timeout watchdog that completes hung transfers.

Parameters:
AW, 18, word-address width; all address buses are [AW-1:2]
TMO, 255, cycles to wait for mwb_ack_i before forced completion (2..65535)

Ports:
sys_clk_i  in  1  system clock, rising edge
sys_rst_i  in  1  reset; asynchronous, active-high
iwb_adr_i  in  AW-2  instruction word address
iwb_stb_i  in  1  instruction strobe
iwb_sel_i  in  4  instruction byte select
iwb_tag_i  in  1  instruction tag (thread id)
iwb_ack_o  out  1  instruction acknowledge
iwb_dat_o  out  32  instruction read data
dwb_adr_i  in  AW-2  data word address
dwb_stb_i  in  1  data strobe
dwb_wre_i  in  1  data write enable
dwb_sel_i  in  4  data byte select
dwb_tag_i  in  1  data tag
dwb_dat_i  in  32  data write data
dwb_ack_o  out  1  data acknowledge
dwb_dat_o  out  32  data read data
mwb_adr_o  out  AW-2  slave address
mwb_stb_o  out  1  slave strobe
mwb_cyc_o  out  1  slave cycle (equals mwb_stb_o)
mwb_wre_o  out  1  slave write enable
mwb_sel_o  out  4  slave byte select
mwb_tag_o  out  1  slave tag
mwb_dat_o  out  32  slave write data
mwb_ack_i  in  1  slave acknowledge
mwb_dat_i  in  32  slave read data
arb_gnt_o  out  2  current grant: 00 none, 01 iwb, 10 dwb
arb_tmo_o  out  1  sticky timeout flag

Behaviour:
- Reset: sys_clk_i is the only clock. sys_rst_i is asynchronous and active-high. While reset is asserted, all mwb_* outputs are 0, iwb_ack_o=dwb_ack_o=0, arb_gnt_o=00, arb_tmo_o=0, the timeout counter is 0 and last-grant=I. If reset asserts mid-transfer, the transfer is abandoned; no ack is sent to any master.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Samples the strobes on each rising edge.
  - Only iwb_stb_i=1: go to GNT_I.
  - Only dwb_stb_i=1: go to GNT_D.
  - Both: grant the master not granted last. After reset, last=I, so dwb wins the first tie.
  - Neither: stay in IDLE.
- Grant latency: the strobe sampled at edge N produces mwb_stb_o=mwb_cyc_o=1 registered from edge N. The requester's adr, sel, tag (and, for dwb, wre and dat) are registered at the same edge.
- GNT_I drives mwb_wre_o=0 and mwb_dat_o=0.
- Granted state:
  - mwb_ack_i is forwarded combinationally to the granted master's ack_o. mwb_dat_i is forwarded combinationally to that master's dat_o.
  - The non-granted master's ack_o is always 0. Its dat_o holds 0.
  - The edge after mwb_ack_i=1: return to IDLE, clear mwb_stb_o, mwb_cyc_o and mwb_wre_o, update last-grant.
  - Back-to-back transfers therefore need at least one IDLE cycle between grants.
- Master obligation: a master drops its stb the cycle after receiving ack. The arbiter only samples stb in IDLE, so a stale stb is never seen.
- Master inputs are ignored while in a granted state. Latched address and data are held stable until ack.
- arb_gnt_o mirrors the state: IDLE=00, GNT_I=01, GNT_D=10.
- Timeout:
  - The counter clears on entry to a granted state and increments each granted cycle without mwb_ack_i.
  - If the counter reaches TMO-1 with no mwb_ack_i, the arbiter pulses the granted master's ack_o for 1 cycle with dat_o=32'h0. It then returns to IDLE, drops mwb_stb_o, and sets arb_tmo_o=1 until reset.
  - If mwb_ack_i arrives in that same final cycle, it is a normal completion: slave data is forwarded and arb_tmo_o is not set.
- A slave ack arriving in IDLE (late ack) is ignored and not forwarded to either master.
- There is no combinational path from any master input to any mwb_* output. All mwb outputs are registered.

Test Plan:
- Reset mid-transfer: assert sys_rst_i asynchronously between clock edges while in GNT_D. Required: mwb_stb_o=0 immediately, no ack to either master, and the first grant after release goes to dwb on a tie.
- Single iwb read: iwb_stb_i=1, adr=0x0040, slave acks on the 3rd cycle with 0xB8000000. Required: mwb_adr_o=0x0040, mwb_wre_o=0, iwb_ack_o high for exactly 1 cycle with iwb_dat_o=0xB8000000, dwb_ack_o=0 throughout.
- Simultaneous requests after reset: iwb and dwb strobe on the same edge, dwb is a write of 0x12345678, sel=F, to 0x0100, iwb read from 0x0004. Required: dwb is granted first (arb_gnt_o=10), then arb_gnt_o=00 for 1 cycle, then iwb is granted (01). mwb_dat_o=0x12345678 during GNT_D.
- Round-robin fairness: both masters request continuously for 6 transfers with the slave acking 1 cycle after stb. Required: grant order D,I,D,I,D,I with no master granted twice in a row.
- Timeout: TMO=8, dwb read, slave never acks. Required: dwb_ack_o pulses on the 8th granted cycle with dwb_dat_o=0, mwb_stb_o=0 on the next cycle, arb_tmo_o=1 and it stays 1. A later slave ack in IDLE produces no master ack.
- Byte-lane passthrough: dwb writes with sel=1,2,4,8,3,C. Required: mwb_sel_o and mwb_tag_o equal the inputs latched at grant, unchanged even if dwb inputs change before ack.
